// File: rtl/gpu_csr_bank_pkg.sv
// Shared types, register map and bit indices for the GPU CSR bank and its status block.
// Shadowing of the active configuration is selected by GPU_CSR_SHADOW_EN (see gpu_csr_bank).
package gpu_csr_bank_pkg;

    localparam int CAM_W     = 32;
    localparam int CAM_WORDS = 15;
    localparam int MAX_VIEWS = 8;

    typedef struct packed {
        logic [CAM_W-1:0] x;
        logic [CAM_W-1:0] y;
        logic [CAM_W-1:0] z;
    } vec3;

    // pos occupies the top bits so word 0 of a camera set maps to pos.x
    typedef struct packed {
        vec3        pos;
        vec3 [0:3]  look;
    } camera;

    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_BUSY = 1'b1
    } rstate_e;

    localparam logic [31:0] DEFAULT_BUFFER = 32'h0010_0000;

    localparam int REG_PIXEL    = 8'h00;
    localparam int REG_VOXEL    = 8'h01;
    localparam int REG_COUNT    = 8'h02;
    localparam int REG_PALETTE  = 8'h03;
    localparam int REG_PAL_LEN  = 8'h04;
    localparam int REG_VIEW_SEL = 8'h05;
    localparam int REG_IRQ_EN   = 8'h0d;
    localparam int REG_STATUS   = 8'h0e;
    localparam int REG_CONTROL  = 8'h0f;
    localparam int REG_CAM_BASE = 8'h10;
    localparam int CAM_STRIDE   = 16;

    localparam int ST_BUSY      = 0;
    localparam int ST_PENDING   = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTL_KICK     = 0;
    localparam int CTL_CLR_PEND = 1;
    localparam int CTL_CLR_OVR  = 2;

endpackage

// File: rtl/gpu_status_irq.sv
// Frame status tracker: busy, pending, overrun, frame counter and the registered interrupt.
//
// state   | meaning
// RS_IDLE | no frame in flight; a kick is accepted
// RS_BUSY | frame rendering; a kick is rejected and flags overrun
module gpu_status_irq
    import gpu_csr_bank_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        kick_i,
    input  logic        clr_pending_i,
    input  logic        clr_overrun_i,
    input  logic        render_done_i,
    input  logic        irq_enable_i,
    output logic        kick_accept_o,
    output logic [15:0] status_o,
    output logic        irq_o
);

    rstate_e    state_q, state_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       irq_q, irq_d;
    logic [7:0] count_q, count_d;
    logic       done_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RS_IDLE;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
            count_q   <= count_d;
        end
    end

    // Completion is applied before the kick so a kick in the done cycle is accepted,
    // and sets win over same-cycle clears.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        count_d       = count_q;
        kick_accept_o = 1'b0;
        done_ok       = render_done_i && (state_q == RS_BUSY);
        irq_d         = pending_q & irq_enable_i;

        if (clr_pending_i) pending_d = 1'b0;
        if (clr_overrun_i) overrun_d = 1'b0;

        if (done_ok) begin
            state_d   = RS_IDLE;
            pending_d = 1'b1;
            count_d   = count_q + 8'd1;
        end

        if (kick_i) begin
            if (state_d == RS_IDLE) begin
                kick_accept_o = 1'b1;
                state_d       = RS_BUSY;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        status_o                        = '0;
        status_o[ST_BUSY]               = (state_q == RS_BUSY);
        status_o[ST_PENDING]            = pending_q;
        status_o[ST_OVERRUN]            = overrun_q;
        status_o[ST_COUNT_LSB +: 8]     = count_q;
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/gpu_csr_bank.sv
// Avalon-MM CSR bank for the voxel GPU: staged buffers, per-view cameras, kick/commit and status.
// Define GPU_CSR_SHADOW_EN to hold the active configuration in shadows committed on each accepted kick.
module gpu_csr_bank
    import gpu_csr_bank_pkg::*;
#(
    parameter int NUM_VIEWS = 2,
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] s1_address,
    input  logic                 s1_read,
    input  logic                 s1_write,
    input  logic [DATA_BITS-1:0] s1_writedata,
    output logic [DATA_BITS-1:0] s1_readdata,
    output logic                 s1_waitrequest,
    input  logic                 render_done,
    output logic                 do_render,
    output logic [DATA_BITS-1:0] pixel_buffer,
    output logic [DATA_BITS-1:0] voxel_buffer,
    output logic [DATA_BITS-1:0] voxel_count,
    output logic [DATA_BITS-1:0] palette_buffer,
    output logic [DATA_BITS-1:0] palette_length,
    output camera                cam,
    output logic [2:0]           active_view,
    output logic                 irq
);

    localparam logic [DATA_BITS-1:0]  RESET_PIXEL = DATA_BITS'(DEFAULT_BUFFER);
    localparam logic [ADDR_BITS-5:0]  HI_FIRST    = (ADDR_BITS-4)'(REG_CAM_BASE / CAM_STRIDE);
    localparam logic [ADDR_BITS-5:0]  HI_LAST     = (ADDR_BITS-4)'(REG_CAM_BASE / CAM_STRIDE + NUM_VIEWS - 1);

    logic [DATA_BITS-1:0]         stage_q [5];
    logic [2:0]                   view_sel_q;
    logic                         irq_en_q;
    logic [CAM_WORDS*CAM_W-1:0]   cams_q [MAX_VIEWS];
    logic [DATA_BITS-1:0]         rdata_q, rdata_d;
    logic                         rd_phase_q;
    logic                         do_render_q;

    logic [ADDR_BITS-5:0] addr_hi;
    logic [3:0]           addr_lo;
    logic                 cam_hit;
    logic [2:0]           cam_view;
    int                   cam_lsb;
    logic                 wr_ctl, kick, clr_pend, clr_ovr, kick_accept;
    logic [15:0]          status;

    assign addr_hi  = s1_address[ADDR_BITS-1:4];
    assign addr_lo  = s1_address[3:0];
    assign cam_hit  = (addr_hi >= HI_FIRST) && (addr_hi <= HI_LAST) && (addr_lo != 4'hf);
    assign cam_view = 3'(addr_hi - HI_FIRST);
    assign cam_lsb  = (CAM_WORDS - 1 - int'(addr_lo)) * CAM_W;

    assign wr_ctl   = s1_write && (s1_address == ADDR_BITS'(REG_CONTROL));
    assign kick     = wr_ctl && s1_writedata[CTL_KICK];
    assign clr_pend = wr_ctl && s1_writedata[CTL_CLR_PEND];
    assign clr_ovr  = wr_ctl && s1_writedata[CTL_CLR_OVR];

    gpu_status_irq u_status (
        .clock         (clock),
        .reset         (reset),
        .kick_i        (kick),
        .clr_pending_i (clr_pend),
        .clr_overrun_i (clr_ovr),
        .render_done_i (render_done),
        .irq_enable_i  (irq_en_q),
        .kick_accept_o (kick_accept),
        .status_o      (status),
        .irq_o         (irq)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) stage_q[i] <= (i == 0) ? RESET_PIXEL : '0;
            for (int v = 0; v < MAX_VIEWS; v++) cams_q[v] <= '0;
            view_sel_q <= 3'd0;
            irq_en_q   <= 1'b0;
        end else if (s1_write) begin
            case (s1_address)
                ADDR_BITS'(REG_PIXEL):   stage_q[0] <= s1_writedata;
                ADDR_BITS'(REG_VOXEL):   stage_q[1] <= s1_writedata;
                ADDR_BITS'(REG_COUNT):   stage_q[2] <= s1_writedata;
                ADDR_BITS'(REG_PALETTE): stage_q[3] <= s1_writedata;
                ADDR_BITS'(REG_PAL_LEN): stage_q[4] <= s1_writedata;
                ADDR_BITS'(REG_VIEW_SEL): begin
                    if (s1_writedata < DATA_BITS'(NUM_VIEWS)) view_sel_q <= 3'(s1_writedata);
                end
                ADDR_BITS'(REG_IRQ_EN):  irq_en_q <= s1_writedata[0];
                default: begin
                    if (cam_hit) cams_q[cam_view][cam_lsb +: CAM_W] <= CAM_W'(s1_writedata);
                end
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (s1_address)
            ADDR_BITS'(REG_PIXEL):    rdata_d = stage_q[0];
            ADDR_BITS'(REG_VOXEL):    rdata_d = stage_q[1];
            ADDR_BITS'(REG_COUNT):    rdata_d = stage_q[2];
            ADDR_BITS'(REG_PALETTE):  rdata_d = stage_q[3];
            ADDR_BITS'(REG_PAL_LEN):  rdata_d = stage_q[4];
            ADDR_BITS'(REG_VIEW_SEL): rdata_d = DATA_BITS'(view_sel_q);
            ADDR_BITS'(REG_IRQ_EN):   rdata_d = DATA_BITS'(irq_en_q);
            ADDR_BITS'(REG_STATUS):   rdata_d = DATA_BITS'(status);
            default: begin
                if (cam_hit) rdata_d = DATA_BITS'(cams_q[cam_view][cam_lsb +: CAM_W]);
            end
        endcase
    end

    // Every read is two cycles: capture with waitrequest high, then present the data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q     <= '0;
            rd_phase_q  <= 1'b0;
            do_render_q <= 1'b0;
        end else begin
            do_render_q <= kick_accept;
            rd_phase_q  <= s1_read && !rd_phase_q;
            if (s1_read && !rd_phase_q) rdata_q <= rdata_d;
        end
    end

    assign s1_readdata    = rdata_q;
    assign s1_waitrequest = s1_read && !rd_phase_q;
    assign do_render      = do_render_q;

`ifdef GPU_CSR_SHADOW_EN
    logic [DATA_BITS-1:0]       shadow_q [5];
    logic [CAM_WORDS*CAM_W-1:0] shcam_q;
    logic [2:0]                 av_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) shadow_q[i] <= (i == 0) ? RESET_PIXEL : '0;
            shcam_q <= '0;
            av_q    <= 3'd0;
        end else if (kick_accept) begin
            for (int i = 0; i < 5; i++) shadow_q[i] <= stage_q[i];
            shcam_q <= cams_q[view_sel_q];
            av_q    <= view_sel_q;
        end
    end

    assign pixel_buffer   = shadow_q[0];
    assign voxel_buffer   = shadow_q[1];
    assign voxel_count    = shadow_q[2];
    assign palette_buffer = shadow_q[3];
    assign palette_length = shadow_q[4];
    assign cam            = camera'(shcam_q);
    assign active_view    = av_q;
`else
    assign pixel_buffer   = stage_q[0];
    assign voxel_buffer   = stage_q[1];
    assign voxel_count    = stage_q[2];
    assign palette_buffer = stage_q[3];
    assign palette_length = stage_q[4];
    assign cam            = camera'(cams_q[view_sel_q]);
    assign active_view    = view_sel_q;
`endif

endmodule

// File: doc/gpu_csr_bank.md
# gpu_csr_bank

Parametrised control/status register bank for the voxel GPU, sitting between the Avalon-MM slave `s1` and `gpu_controller`. It holds staged buffer pointers and `NUM_VIEWS` camera sets. On a render kick it commits the staged configuration and the selected view into shadow registers that stay stable for the whole frame. It also tracks busy, interrupt-pending, overrun and frame-count status and drives `irq` with an enable mask.

## Interface
- `NUM_VIEWS`, default 2, number of camera sets; range 1..8.
- `DATA_BITS`, default 32, slave data width and width of each register.
- `ADDR_BITS`, default 8, slave word-address width.
- `clock`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `s1_address`  in  ADDR_BITS  word address.
- `s1_read` / `s1_write`  in  1  Avalon read and write strobes.
- `s1_writedata`  in  DATA_BITS  write data.
- `s1_readdata`  out  DATA_BITS  registered read data.
- `s1_waitrequest`  out  1  read stall.
- `render_done`  in  1  one-cycle pulse from the controller when a frame is finished.
- `do_render`  out  1  one-cycle start pulse to the controller.
- `pixel_buffer`, `voxel_buffer`, `voxel_count`, `palette_buffer`, `palette_length`  out  DATA_BITS each  active (shadow) values.
- `cam`  out  `camera`  active camera.
- `active_view`  out  3  view index committed at the last kick.
- `irq`  out  1  level interrupt.

## Operation
- Address map:
  - 0x00–0x04: staged pixel, voxel, count, palette and palette-length registers, RW.
  - 0x05: `view_select`, RW. A write with value ≥ NUM_VIEWS is ignored.
  - 0x0d: `irq_enable`, RW, bit 0 only.
  - 0x0e: status, RO. Bit 0 busy, bit 1 pending, bit 2 overrun, bits [15:8] frame_count.
  - 0x0f: control, write-only, reads 0.
  - View v camera: 0x10+16·v … 0x1e+16·v, holding pos.x/y/z, then look0–look3, each x/y/z, RW.
  - Unmapped addresses and views ≥ NUM_VIEWS: writes ignored, reads 0.
- Control write:
  - Bit 0 is kick.
  - Bit 1 is clear-pending (write-1-to-clear).
  - Bit 2 is clear-overrun.
  - Any combination is allowed in one write.
- Kick when idle:
  - Copies all staged registers, plus camera set `view_select`, into the shadow registers.
  - Sets `active_view`.
  - Sets busy and pulses `do_render`.
- Kick when busy: ignored; overrun is set.
- `render_done` when busy: clears busy, sets pending and increments frame_count (mod 256). `render_done` when idle: ignored.
- `irq` = pending & irq_enable, registered.
- Staged registers may be written at any time, including while busy. Shadow outputs do not change until the next accepted kick.
- Simultaneous events:
  - `render_done` and kick in the same cycle: done is applied first, then the kick is accepted. Result: busy=1, pending=1, count+1, no overrun.
  - Clear-pending and `render_done` in the same cycle: pending ends 1 (set wins).
  - Clear-overrun together with a rejected kick: overrun ends 1.
- Reset values:
  - All registers and shadows are 0, except staged and shadow `pixel_buffer` = `DEFAULT_BUFFER`.
  - `view_select`=0, `active_view`=0, `irq_enable`=0.
  - busy, pending, overrun, frame_count = 0.
  - `do_render`=0, `irq`=0, `s1_readdata`=0, `s1_waitrequest`=0.
  - Reset during a render abandons it. A later `render_done` is ignored because busy=0.

## Timing
- Writes take zero wait states and take effect at the edge where `s1_write` is sampled.
- Kick accepted at edge N: `do_render`=1 and the shadow outputs are updated during cycle N+1. `do_render` is 0 again at N+2.
- Reads:
  - First cycle of `s1_read`: `s1_waitrequest`=1 and `s1_readdata` is captured.
  - Second cycle: `s1_waitrequest`=0 and data is valid.
  - Every read costs exactly 2 cycles. Back-to-back reads are 2 cycles each.
- `irq` follows a pending or enable change by 1 cycle. Status read data reflects state at the capture edge.

## Configuration
- `GPU_CSR_SHADOW_EN` defined: behaviour as above, with double-buffered shadows.
- Not defined:
  - No shadow registers are built.
  - Active outputs are wired directly to the staged registers, and `cam` to camera set `view_select`.
  - `active_view` = `view_select`.
  - Kick, busy, pending and irq behaviour is unchanged.

## Structure
- The shared package holds:
  - the `vec3` and `camera` typedefs and `DEFAULT_BUFFER`;
  - register address localparams: `REG_PIXEL`…`REG_CONTROL`, `REG_CAM_BASE`, `CAM_STRIDE`=16;
  - status bit indices and control bit indices.
- One sub-module, `gpu_status_irq`, owns busy, pending, overrun, frame_count and `irq`. Its inputs are kick, clear-pending, clear-overrun, `render_done` and `irq_enable`. Its outputs are `kick_accept`, status and `irq`.

## Test plan
- Reset, then read 0x00 and 0x0e → 2-cycle read each; `DEFAULT_BUFFER` and 0x0000_0000.
- Write 0x01=0x1000, 0x05=1, view-1 pos.x (0x20)=0x0005_0000, then 0x0f=1 → `do_render` high for exactly one cycle; `voxel_buffer`=0x1000, `cam.pos.x`=0x0005_0000, `active_view`=1.
- While busy, write 0x01=0x2000 and kick again → `voxel_buffer` stays 0x1000; status reads 0x0000_0005 (busy and overrun).
- `irq_enable`=1, pulse `render_done` → `irq` high next cycle; status 0x0000_0106. Write 0x0f=0x6 → `irq` low; status 0x0000_0100.
- `render_done` in the same cycle as a kick write → busy=1, pending=1, frame_count+1, `do_render` pulses once, overrun=0.
- Write 0x05=NUM_VIEWS, and write/read address 0x10+16·NUM_VIEWS → `view_select` unchanged; read returns 0.
